// File: rtl/registerfile.sv
// registerfile: 16 x 32-bit general registers plus the 4-bit ALU status
// register. This is the receiving end of the stage-2 writeback path, and it
// serves three combinational read ports with same-cycle write forwarding.
module registerfile #(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic [3:0]  write_index,
  input  logic [31:0] write_data,
  input  logic        write_immediate,
  input  logic [15:0] write_immediate_data,
  input  logic [1:0]  write_immediate_type,
  input  logic        status_register_write,
  input  logic        alu_carry_in,
  input  logic        alu_zero_in,
  input  logic        alu_neg_in,
  input  logic        alu_over_in,
  input  logic [3:0]  read_reg_left_index,
  input  logic [3:0]  read_reg_right_index,
  input  logic [3:0]  read_reg_data_index,
  output logic [31:0] reg_left_data,
  output logic [31:0] reg_right_data,
  output logic [31:0] reg_data_data,
  output logic        alu_carry,
  output logic        alu_zero,
  output logic        alu_neg,
  output logic        alu_over
);

  // Immediate type encodings shared with the decoder.
  localparam logic [1:0] IT_UNSIGNED   = 2'd0;
  localparam logic [1:0] IT_SIGNED     = 2'd1;
  localparam logic [1:0] IT_TOPHALF    = 2'd2;
  localparam logic [1:0] IT_BOTTOMHALF = 2'd3;

  // Build the 32-bit immediate word. Half merges keep the other half of the
  // destination register as it stands before the clock edge.
  function automatic logic [31:0] imm_merge(
    input logic [1:0]  it,
    input logic [15:0] imm,
    input logic [31:0] old_value
  );
    logic signed [15:0] simm;
    logic [31:0]        result;
    simm   = signed'(imm);
    result = {16'h0, imm};
    case (it)
      IT_UNSIGNED:   result = {16'h0, imm};
      IT_SIGNED:     result = 32'(simm);
      IT_TOPHALF:    result = {imm, old_value[15:0]};
      IT_BOTTOMHALF: result = {old_value[31:16], imm};
      default:       result = {16'h0, imm};
    endcase
    return result;
  endfunction

  // One read port: a pending write to the same index is forwarded so the
  // earlier pipeline stages see the value in the same cycle it is written.
  // A full write beats an immediate write, matching the array update.
  function automatic logic [31:0] read_port(
    input logic [3:0]  idx,
    input logic [31:0] stored,
    input logic        wr_full,
    input logic        wr_imm,
    input logic [3:0]  wr_idx,
    input logic [31:0] wr_full_data,
    input logic [31:0] wr_imm_data
  );
    logic [31:0] result;
    result = stored;
    if (wr_full && idx == wr_idx) begin
      result = wr_full_data;
    end else if (wr_imm && idx == wr_idx) begin
      result = wr_imm_data;
    end
    return result;
  endfunction

  logic [31:0] regs [NUM_REGS];
  logic [31:0] imm32;
  logic [31:0] wr_value;
  logic        wr_en;

  logic carry_q;
  logic zero_q;
  logic neg_q;
  logic over_q;

  assign imm32    = imm_merge(write_immediate_type, write_immediate_data,
                              regs[write_index]);
  assign wr_en    = write | write_immediate;
  assign wr_value = write ? write_data : imm32;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [31:0] q;

    // Register g: reset loads RESET_VALUE, otherwise load on an indexed write.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        q <= RESET_VALUE;
      end else if (wr_en && write_index == 4'(g)) begin
        q <= wr_value;
      end
    end

    assign regs[g] = q;
  end

  // Status flags latch together on the strobe and otherwise hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      over_q  <= 1'b0;
    end else if (status_register_write) begin
      carry_q <= alu_carry_in;
      zero_q  <= alu_zero_in;
      neg_q   <= alu_neg_in;
      over_q  <= alu_over_in;
    end
  end

  // Flags are not forwarded: new values appear the cycle after the edge.
  assign alu_carry = carry_q;
  assign alu_zero  = zero_q;
  assign alu_neg   = neg_q;
  assign alu_over  = over_q;

  assign reg_left_data  = read_port(read_reg_left_index, regs[read_reg_left_index],
                                    write, write_immediate, write_index,
                                    write_data, imm32);
  assign reg_right_data = read_port(read_reg_right_index, regs[read_reg_right_index],
                                    write, write_immediate, write_index,
                                    write_data, imm32);
  assign reg_data_data  = read_port(read_reg_data_index, regs[read_reg_data_index],
                                    write, write_immediate, write_index,
                                    write_data, imm32);

`ifndef SYNTHESIS
  // Simulation-only notice when both write strobes collide; the full write wins.
  always @(posedge clock) begin
    if (reset && write && write_immediate) begin
      $display("registerfile: warning: write and write_immediate both set for r%0d at %0t, immediate discarded",
               write_index, $time);
    end
  end
`endif

endmodule

// File: tb/tb_registerfile.sv
// Bench for registerfile: directed steps from the test plan followed by
// randomized traffic, all compared against an array-based reference model.
module tb_registerfile;

  localparam logic [1:0] IT_UNSIGNED   = 2'd0;
  localparam logic [1:0] IT_SIGNED     = 2'd1;
  localparam logic [1:0] IT_TOPHALF    = 2'd2;
  localparam logic [1:0] IT_BOTTOMHALF = 2'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic        write;
  logic [3:0]  write_index;
  logic [31:0] write_data;
  logic        write_immediate;
  logic [15:0] write_immediate_data;
  logic [1:0]  write_immediate_type;
  logic        status_register_write;
  logic        alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in;
  logic [3:0]  read_reg_left_index, read_reg_right_index, read_reg_data_index;
  logic [31:0] reg_left_data, reg_right_data, reg_data_data;
  logic        alu_carry, alu_zero, alu_neg, alu_over;

  int checks   = 0;
  int failures = 0;

  // Reference state: register contents and flags {carry, zero, neg, over}.
  logic [31:0] m [16];
  logic [3:0]  mflags;

  registerfile dut (
    .clock                 (clock),
    .reset                 (reset),
    .write                 (write),
    .write_index           (write_index),
    .write_data            (write_data),
    .write_immediate       (write_immediate),
    .write_immediate_data  (write_immediate_data),
    .write_immediate_type  (write_immediate_type),
    .status_register_write (status_register_write),
    .alu_carry_in          (alu_carry_in),
    .alu_zero_in           (alu_zero_in),
    .alu_neg_in            (alu_neg_in),
    .alu_over_in           (alu_over_in),
    .read_reg_left_index   (read_reg_left_index),
    .read_reg_right_index  (read_reg_right_index),
    .read_reg_data_index   (read_reg_data_index),
    .reg_left_data         (reg_left_data),
    .reg_right_data        (reg_right_data),
    .reg_data_data         (reg_data_data),
    .alu_carry             (alu_carry),
    .alu_zero              (alu_zero),
    .alu_neg               (alu_neg),
    .alu_over              (alu_over)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model_imm();
    logic [31:0] old_value;
    logic [15:0] d;
    old_value = m[write_index];
    d = write_immediate_data;
    case (write_immediate_type)
      IT_UNSIGNED:   return {16'h0000, d};
      IT_SIGNED:     return {(d[15] ? 16'hFFFF : 16'h0000), d};
      IT_TOPHALF:    return {d, old_value[15:0]};
      default:       return {old_value[31:16], d};
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] idx);
    if (write && idx == write_index) return write_data;
    if (write_immediate && idx == write_index) return model_imm();
    return m[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_left"},  reg_left_data,  model_read(read_reg_left_index));
    check({tag, "_right"}, reg_right_data, model_read(read_reg_right_index));
    check({tag, "_data"},  reg_data_data,  model_read(read_reg_data_index));
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_flags"}, {28'h0, alu_carry, alu_zero, alu_neg, alu_over}, {28'h0, mflags});
  endtask

  task automatic idle();
    write = 1'b0;
    write_immediate = 1'b0;
    status_register_write = 1'b0;
  endtask

  task automatic set_reads(input logic [3:0] l, input logic [3:0] r, input logic [3:0] d);
    read_reg_left_index = l;
    read_reg_right_index = r;
    read_reg_data_index = d;
  endtask

  // Advance one clock edge, updating the model from the inputs held at the edge.
  task automatic tick();
    logic [31:0] nv;
    logic        we;
    logic [3:0]  nf;
    we = write | write_immediate;
    nv = write ? write_data : model_imm();
    nf = {alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in};
    @(posedge clock);
    if (reset) begin
      if (we) m[write_index] = nv;
      if (status_register_write) mflags = nf;
    end
    #1;
  endtask

  task automatic full_write(input logic [3:0] idx, input logic [31:0] d);
    idle();
    write = 1'b1;
    write_index = idx;
    write_data = d;
  endtask

  task automatic imm_write(input logic [3:0] idx, input logic [1:0] it, input logic [15:0] d);
    idle();
    write_immediate = 1'b1;
    write_index = idx;
    write_immediate_type = it;
    write_immediate_data = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    mflags = 4'h0;
    idle();
    reset = 1'b0;
    write_index = 4'd0;
    write_data = 32'h0;
    write_immediate_data = 16'h0;
    write_immediate_type = IT_UNSIGNED;
    {alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in} = 4'b0000;
    set_reads(4'd0, 4'd7, 4'd15);
    #2;
    check_reads("reset_init");
    check_flags("reset_init");
    tick();
    @(negedge clock);
    reset = 1'b1;
    #1;

    // Full write with same-cycle forwarding, then readback from the array.
    full_write(4'd3, 32'h12345678);
    set_reads(4'd3, 4'd0, 4'd5);
    #1;
    check("fwd_full_r3", reg_left_data, 32'h12345678);
    check_reads("fwd_full");
    tick();
    idle();
    #1;
    check("array_r3", reg_left_data, 32'h12345678);

    // Immediate types on r7 and r2.
    full_write(4'd7, 32'hAAAABBBB);
    tick();
    imm_write(4'd7, IT_TOPHALF, 16'h1234);
    set_reads(4'd7, 4'd7, 4'd3);
    #1;
    check("tophalf_fwd", reg_left_data, 32'h1234BBBB);
    tick();
    idle();
    #1;
    check("tophalf", reg_right_data, 32'h1234BBBB);
    imm_write(4'd7, IT_BOTTOMHALF, 16'h5678);
    tick();
    idle();
    #1;
    check("bottomhalf", reg_left_data, 32'h12345678);
    imm_write(4'd2, IT_SIGNED, 16'h8001);
    set_reads(4'd2, 4'd7, 4'd2);
    tick();
    idle();
    #1;
    check("signed", reg_left_data, 32'hFFFF8001);
    imm_write(4'd2, IT_UNSIGNED, 16'h8001);
    tick();
    idle();
    #1;
    check("unsigned", reg_data_data, 32'h00008001);

    // Both strobes: the full write wins.
    full_write(4'd9, 32'h11111111);
    write_immediate = 1'b1;
    write_immediate_type = IT_UNSIGNED;
    write_immediate_data = 16'h2222;
    set_reads(4'd9, 4'd9, 4'd9);
    #1;
    check("prio_fwd", reg_right_data, 32'h11111111);
    tick();
    idle();
    #1;
    check("prio", reg_left_data, 32'h11111111);

    // Status register latch and hold.
    status_register_write = 1'b1;
    {alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in} = 4'b1010;
    #1;
    check("flags_before_edge", {28'h0, alu_carry, alu_zero, alu_neg, alu_over}, 32'h0);
    tick();
    idle();
    {alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in} = 4'b1111;
    #1;
    check("flags_latched", {28'h0, alu_carry, alu_zero, alu_neg, alu_over}, 32'hA);
    tick();
    check("flags_hold", {28'h0, alu_carry, alu_zero, alu_neg, alu_over}, 32'hA);

    // Multi-port forwarding and stored reads.
    full_write(4'd1, 32'h0BADF00D);
    tick();
    full_write(4'd4, 32'hCAFEF00D);
    set_reads(4'd4, 4'd4, 4'd4);
    #1;
    check("mp_fwd_left", reg_left_data, 32'hCAFEF00D);
    check("mp_fwd_right", reg_right_data, 32'hCAFEF00D);
    check("mp_fwd_data", reg_data_data, 32'hCAFEF00D);
    tick();
    idle();
    set_reads(4'd1, 4'd2, 4'd4);
    #1;
    check("mp_r1", reg_left_data, 32'h0BADF00D);
    check("mp_r2", reg_right_data, 32'h00008001);
    check("mp_r4", reg_data_data, 32'hCAFEF00D);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] sel;
      write = ($urandom_range(0, 2) == 0);
      write_immediate = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) != 0 && write && write_immediate) write_immediate = 1'b0;
      status_register_write = ($urandom_range(0, 3) == 0);
      write_index = 4'($urandom_range(0, 15));
      write_data = $urandom;
      write_immediate_data = 16'($urandom);
      write_immediate_type = 2'($urandom_range(0, 3));
      {alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in} = 4'($urandom_range(0, 15));
      sel = 4'($urandom_range(0, 15));
      read_reg_left_index  = sel[0] ? write_index : 4'($urandom_range(0, 15));
      read_reg_right_index = sel[1] ? write_index : 4'($urandom_range(0, 15));
      read_reg_data_index  = sel[2] ? write_index : 4'($urandom_range(0, 15));
      #1;
      check_reads("rand");
      check_flags("rand");
      tick();
    end
    idle();
    #1;
    for (int i = 0; i < 16; i++) begin
      set_reads(4'(i), 4'(i), 4'(i));
      #1;
      check("sweep", reg_left_data, m[i]);
    end

    // Asynchronous reset mid-cycle, with a write lost under reset.
    full_write(4'd5, 32'hDEADBEEF);
    status_register_write = 1'b1;
    {alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in} = 4'b1111;
    tick();
    idle();
    set_reads(4'd5, 4'd7, 4'd4);
    #1;
    check("pre_reset_r5", reg_left_data, 32'hDEADBEEF);
    check_flags("pre_reset");
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    mflags = 4'h0;
    #1;
    check("async_r5", reg_left_data, 32'h0);
    check("async_r7", reg_right_data, 32'h0);
    check("async_r4", reg_data_data, 32'h0);
    check_flags("async");
    full_write(4'd5, 32'h55AA55AA);
    tick();
    idle();
    #1;
    check("reset_dominates", reg_left_data, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("post_release_r5", reg_left_data, 32'h0);
    tick();
    check("post_release_r5_b", reg_left_data, 32'h0);
    check_flags("post_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/registerfile.md
Name: registerfile

Overview:
- 16 x 32-bit general register file plus 4-bit ALU status register; the receiving end of the stage-2 writeback interface.
- Accepts full-word writes and immediate writes with type-controlled extension or half merge.
- Accepts status flag updates from ALU cycles.
- Serves three combinational read ports to stage 0/1 and the store path, with same-cycle write forwarding.

Parameters:
- NUM_REGS, 16, number of registers; index width fixed at 4.
- RESET_VALUE, 32'h0, value loaded into every register on reset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- write  input  1  full-word write strobe.
- write_index  input  4  destination register for write or write_immediate.
- write_data  input  32  data for a full-word write.
- write_immediate  input  1  immediate write strobe.
- write_immediate_data  input  16  immediate value.
- write_immediate_type  input  2  IT_UNSIGNED, IT_SIGNED, IT_TOPHALF, IT_BOTTOMHALF; encodings per registers.vh.
- status_register_write  input  1  latch ALU flags.
- alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in  input  1 each  flags produced by the ALU this cycle.
- read_reg_left_index, read_reg_right_index, read_reg_data_index  input  4 each  read addresses.
- reg_left_data, reg_right_data, reg_data_data  output  32 each  read data.
- alu_carry, alu_zero, alu_neg, alu_over  output  1 each  current status register; feeds the stage-2 condition evaluator.

Behaviour:
- Reset (reset low, asynchronous):
  - All registers load RESET_VALUE immediately.
  - All status flags go to 0.
  - Read outputs reflect RESET_VALUE combinationally.
  - Release is synchronised by the caller; the block just honours the level.
- Full write: on a rising clock edge with write=1, regs[write_index] <= write_data.
- Immediate write: on a rising clock edge with write_immediate=1, regs[write_index] <= imm32, where imm32 is:
  - IT_UNSIGNED: {16'h0, write_immediate_data}.
  - IT_SIGNED: {{16{write_immediate_data[15]}}, write_immediate_data}.
  - IT_TOPHALF: {write_immediate_data, regs[write_index][15:0]}, i.e. the lower half is retained.
  - IT_BOTTOMHALF: {regs[write_index][31:16], write_immediate_data}, i.e. the upper half is retained.
  - Half merges use the register's pre-edge value.
- write and write_immediate both 1: write wins. The immediate is discarded and a $display warning is issued in simulation. Stage 2 never drives both; the rule only makes the outcome defined.
- Status: on a rising clock edge with status_register_write=1, all four flags latch together from the *_in inputs. Otherwise they hold. Status updates are independent of register writes and may coincide with them.
- Reads: combinational from the array, with forwarding.
  - If an index equals write_index while write=1, the output is write_data.
  - If an index equals write_index while write_immediate=1 (and write=0), the output is imm32.
  - Forwarding applies to all three ports, including when several ports share an index.
- Status outputs are not forwarded; the new flags are visible the cycle after the edge.
- Latency: a write is visible on a read port in the same cycle via forwarding, and from the array on the following cycle.
- Register 0 is an ordinary register with no hardwired value. All 16 indices are writable.
- No state machine. State consists of the array and the status register.
- Simultaneous reset and write: reset dominates and the write is lost.
- Writes with both strobes low never alter state, whatever write_index and data are doing.

Test Plan:
- Reset: hold reset low mid-run after writing r5=32'hDEADBEEF -> all reads return 0 asynchronously, flags 0000; after release, r5 still reads 0.
- Full write and forwarding:
  - write=1, index 3, data 32'h12345678 -> reg_left_data with left index 3 shows 12345678 in the same cycle, before the edge.
  - After the edge, with write=0, it still reads 12345678.
- Immediate types, starting with r7=32'hAAAABBBB:
  - IT_TOPHALF 16'h1234 -> 32'h1234BBBB.
  - Then IT_BOTTOMHALF 16'h5678 -> 32'h12345678.
  - IT_SIGNED 16'h8001 into r2 -> 32'hFFFF8001.
  - IT_UNSIGNED 16'h8001 -> 32'h00008001.
- Priority: write=1 data 32'h11111111 and write_immediate=1 IMM 16'h2222, both to r9 -> r9=32'h11111111 and the warning is printed.
- Status:
  - status_register_write=1 with carry=1, zero=0, neg=1, over=0 -> outputs 1,0,1,0 after the edge.
  - Next cycle, strobe low with new inputs all 1 -> outputs unchanged.
- Multi-port: all three read indices = 4 while writing r4=32'hCAFEF00D -> all three outputs show CAFEF00D.
- Multi-port: indices 1, 2, 4 with no write -> each shows its stored value.
